controller_reader: RTL and testbench

- Polls one NES-style serial gamepad and produces the registered, active-high button levels that the movement FSM consumes (button_up/down/left/right) plus attack/menu buttons.
- Acts as the initiator of the latch/clock/data shift protocol, one instance per player.
- Drives the pad's latch and clock lines, samples its active-low serial data, and presents a clean snapshot once per frame_rate strobe.

---
 rtl/controller_reader.sv | 130 +++++++++++++
 tb/tb_controller_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/controller_reader.sv
// NES-style gamepad poller: drives latch/clock, shifts in eight
// active-low bits and publishes a registered button snapshot.
module controller_reader #(
  parameter  int HALF_PERIOD = 150,
  localparam int CNT_W = $clog2(2*HALF_PERIOD+1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_rate,
  input  logic       ctrl_data,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  output logic       button_a,
  output logic       button_b,
  output logic       button_select,
  output logic       button_start,
  output logic       button_up,
  output logic       button_down,
  output logic       button_left,
  output logic       button_right,
  output logic [7:0] press_pulse,
  output logic       buttons_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, LATCH, WAIT_A, CLK_HIGH, CLK_LOW, UPDATE
  } state_t;

  state_t     state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0] idx_q, idx_n;
  logic [7:0] shift_q, shift_n;
  logic [7:0] prev_q;
  logic [7:0] btn_q;
  logic [1:0] sync_q;
  logic       last;
  logic       pressed;

  assign last    = (cnt_q == '0);
  assign pressed = ~sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], ctrl_data};
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = last ? cnt_q : cnt_q - CNT_W'(1);
    idx_n   = idx_q;
    shift_n = shift_q;
    unique case (state_q)
      IDLE:     if (frame_rate) state_n = LATCH;
      LATCH:    if (last) state_n = WAIT_A;
      WAIT_A: begin
        if (last) begin
          shift_n[0] = pressed;
          idx_n      = 3'd1;
          state_n    = CLK_HIGH;
        end
      end
      CLK_HIGH: if (last) state_n = CLK_LOW;
      CLK_LOW: begin
        if (last) begin
          shift_n[idx_q] = pressed;
          idx_n          = idx_q + 3'd1;
          state_n        = (idx_q == 3'd7) ? UPDATE : CLK_HIGH;
        end
      end
      UPDATE:   state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    // every state entry restarts its own dwell time
    if (state_n != state_q) begin
      unique case (state_n)
        LATCH:   cnt_n = CNT_W'(2*HALF_PERIOD-1);
        WAIT_A,
        CLK_HIGH,
        CLK_LOW: cnt_n = CNT_W'(HALF_PERIOD-1);
        default: cnt_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      prev_q        <= '0;
      btn_q         <= '0;
      press_pulse   <= '0;
      ctrl_latch    <= 1'b0;
      ctrl_clk      <= 1'b0;
      busy          <= 1'b0;
      buttons_valid <= 1'b0;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      idx_q         <= idx_n;
      shift_q       <= shift_n;
      ctrl_latch    <= (state_n == LATCH);
      ctrl_clk      <= (state_n == CLK_HIGH);
      busy          <= (state_n != IDLE);
      buttons_valid <= (state_n == UPDATE);
      press_pulse   <= '0;
      // shift_n already holds bit 7 captured on this same edge
      if (state_n == UPDATE) begin
        btn_q       <= shift_n;
        press_pulse <= shift_n & ~prev_q;
        prev_q      <= shift_n;
      end
    end
  end

  assign button_a      = btn_q[0];
  assign button_b      = btn_q[1];
  assign button_select = btn_q[2];
  assign button_start  = btn_q[3];
  assign button_up     = btn_q[4];
  assign button_down   = btn_q[5];
  assign button_left   = btn_q[6];
  assign button_right  = btn_q[7];

endmodule

// File: tb/tb_controller_reader.sv
// Bench for controller_reader: pad model, scoreboard queue,
// table-driven polls and hand-written protocol/reset sequences.
module tb_controller_reader;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_rate = 1'b0;
  logic       ctrl_data;
  logic       ctrl_latch, ctrl_clk;
  logic       button_a, button_b, button_select, button_start;
  logic       button_up, button_down, button_left, button_right;
  logic [7:0] press_pulse;
  logic       buttons_valid, busy;
  logic [7:0] btns;

  controller_reader #(.HALF_PERIOD(H)) dut (
    .clk(clk), .reset(reset), .frame_rate(frame_rate),
    .ctrl_data(ctrl_data), .ctrl_latch(ctrl_latch), .ctrl_clk(ctrl_clk),
    .button_a(button_a), .button_b(button_b),
    .button_select(button_select), .button_start(button_start),
    .button_up(button_up), .button_down(button_down),
    .button_left(button_left), .button_right(button_right),
    .press_pulse(press_pulse), .buttons_valid(buttons_valid),
    .busy(busy)
  );

  assign btns = {button_right, button_left, button_down, button_up,
                 button_start, button_select, button_b, button_a};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pad: latch loads inverted presses, rising ctrl_clk shifts toward bit 0
  logic [7:0] pad_pressed = 8'h00;
  logic       pad_disc = 1'b0;
  logic [7:0] pad_sr = 8'hff;
  logic       pclk_d = 1'b0;
  always @(posedge clk) begin
    pclk_d <= ctrl_clk;
    if (ctrl_latch) pad_sr <= ~pad_pressed;
    else if (ctrl_clk && !pclk_d) pad_sr <= {1'b1, pad_sr[7:1]};
  end
  assign ctrl_data = pad_disc ? 1'b1 : pad_sr[0];

  typedef struct {
    logic [7:0] btn;
    logic [7:0] press;
  } exp_t;
  typedef struct {
    logic [7:0] btn;
    logic [7:0] press;
    int         cyc;
  } obs_t;
  typedef struct {
    logic [7:0] pressed;
    logic       disc;
    logic [7:0] eb;
    logic [7:0] ep;
  } vec_t;

  exp_t exp_q[$];
  obs_t obs_q[$];

  always @(negedge clk)
    if (buttons_valid) obs_q.push_back('{btns, press_pulse, cyc});

  int checks = 0;
  int errors = 0;
  int t0, lat_cnt, lat_first, clk_rise, clk_hi, overlap, busy_cnt;
  logic [19:0] rst_snap;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drain();
    exp_t e;
    obs_t o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL missing_valid: got none expected btn %0h", e.btn);
      end else begin
        o = obs_q.pop_front();
        chk("buttons", {24'd0, o.btn}, {24'd0, e.btn});
        chk("press_pulse", {24'd0, o.press}, {24'd0, e.press});
      end
    end
    chk("extra_valid", obs_q.size(), 0);
    obs_q.delete();
  endtask

  task automatic do_poll(input logic [7:0] p, input logic d,
                         input logic [7:0] eb, input logic [7:0] ep);
    int n;
    pad_pressed = p;
    pad_disc    = d;
    exp_q.push_back('{eb, ep});
    @(posedge clk); #1 frame_rate = 1'b1;
    @(posedge clk); #1 frame_rate = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL poll_timeout: got busy %0b expected 0", busy);
    end
    repeat (3) @(posedge clk);
    #1 drain();
  endtask

  // one poll request at k=0, optional second request, optional reset
  task automatic window(input int n, input int second, input int rst_at);
    logic pc;
    pc = 1'b0;
    lat_cnt = 0; lat_first = -1; clk_rise = 0;
    clk_hi = 0; overlap = 0; busy_cnt = 0; rst_snap = '1;
    @(posedge clk); #1;
    t0 = cyc;
    frame_rate = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 1 || (second >= 0 && k == second + 1)) frame_rate = 1'b0;
      if (second >= 0 && k == second) frame_rate = 1'b1;
      if (ctrl_latch) begin
        lat_cnt++;
        if (lat_first < 0) lat_first = cyc - t0;
      end
      if (ctrl_clk) begin
        clk_hi++;
        if (!pc) clk_rise++;
      end
      pc = ctrl_clk;
      if (ctrl_latch && ctrl_clk) overlap++;
      if (busy) busy_cnt++;
      if (k == rst_at) begin
        reset = 1'b0;
        #1 rst_snap = {ctrl_latch, ctrl_clk, busy, buttons_valid,
                       btns, press_pulse};
      end
      if (rst_at >= 0 && k == rst_at + 3) reset = 1'b1;
    end
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'h00, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{8'h01, 1'b0, 8'h01, 8'h01};
    vecs[2] = '{8'h01, 1'b0, 8'h01, 8'h00};
    vecs[3] = '{8'h40, 1'b0, 8'h40, 8'h40};
    vecs[4] = '{8'h40, 1'b1, 8'h00, 8'h00};
    vecs[5] = '{8'hff, 1'b0, 8'hff, 8'hff};
    vecs[6] = '{8'hff, 1'b0, 8'hff, 8'h00};
    vecs[7] = '{8'h55, 1'b0, 8'h55, 8'h00};
    vecs[8] = '{8'haa, 1'b0, 8'haa, 8'haa};
    vecs[9] = '{8'h90, 1'b0, 8'h90, 8'h10};

    repeat (3) @(negedge clk);
    chk("reset_state",
        {12'd0, ctrl_latch, ctrl_clk, busy, buttons_valid, btns, press_pulse},
        32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);

    pad_pressed = 8'h90;
    pad_disc    = 1'b0;
    window(30, -1, 20);
    chk("midpoll_reset_outputs", {12'd0, rst_snap}, 32'd0);
    chk("midpoll_buttons_after", {24'd0, btns}, 32'd0);
    chk("midpoll_no_valid", obs_q.size(), 0);
    obs_q.delete();
    repeat (3) @(negedge clk);

    exp_q.push_back('{8'h90, 8'h90});
    window(80, -1, -1);
    chk("latch_cycles", lat_cnt, 2*H);
    chk("latch_start", lat_first, 1);
    chk("clk_pulses", clk_rise, 7);
    chk("clk_high_cycles", clk_hi, 28);
    chk("latch_clk_overlap", overlap, 0);
    chk("busy_cycles", busy_cnt, 17*H+1);
    chk("valid_count", obs_q.size(), 1);
    if (obs_q.size() > 0) chk("valid_time", obs_q[0].cyc - t0, 17*H+1);
    drain();

    for (int i = 0; i < 10; i++)
      do_poll(vecs[i].pressed, vecs[i].disc, vecs[i].eb, vecs[i].ep);

    pad_pressed = 8'h08;
    pad_disc    = 1'b0;
    exp_q.push_back('{8'h08, 8'h08});
    window(100, 30, -1);
    chk("ignored_valid_count", obs_q.size(), 1);
    if (obs_q.size() > 0) chk("ignored_valid_time", obs_q[0].cyc - t0, 17*H+1);
    chk("ignored_busy_cycles", busy_cnt, 17*H+1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
